// File: rtl/redghost_controller_if.sv
// redghost_controller_if: frame/pacman/wall inputs and ghost state outputs of the red-ghost engine
interface redghost_controller_if;
  logic       frame_tick;
  logic       game_en;
  logic [9:0] pX;
  logic [9:0] pY;
  logic       wall_up;
  logic       wall_down;
  logic       wall_left;
  logic       wall_right;
  logic [9:0] redghostX;
  logic [9:0] redghostY;
  logic [9:0] redghost_size;
  logic [7:0] lives;
  logic [1:0] dir;
  logic       hit;
  logic       game_over;
  modport master (
    output frame_tick, game_en, pX, pY, wall_up, wall_down, wall_left, wall_right,
    input  redghostX, redghostY, redghost_size, lives, dir, hit, game_over
  );
  modport slave (
    input  frame_tick, game_en, pX, pY, wall_up, wall_down, wall_left, wall_right,
    output redghostX, redghostY, redghost_size, lives, dir, hit, game_over
  );
endinterface

// File: rtl/redghost_controller.sv
// redghost_controller: per-frame red-ghost chase, wall avoidance, catch detection and lives
module redghost_controller #(
  parameter int START_X    = 202,
  parameter int START_Y    = 200,
  parameter int SIZE       = 12,
  parameter int STEP       = 1,
  parameter int MOVE_DIV   = 2,
  parameter int HIT_DIST   = 20,
  parameter int FREEZE_FR  = 60,
  parameter int LIVES_INIT = 3
) (
  input logic Clk,
  input logic Reset,
  redghost_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CHASE, HIT, OVER} state_t;
  localparam logic signed [11:0] ST  = 12'(STEP);
  localparam logic signed [11:0] LO  = 12'(SIZE);
  localparam logic signed [11:0] XHI = 12'(404 - SIZE);
  localparam logic signed [11:0] YHI = 12'(447 - SIZE);
  localparam logic [7:0] MOVE_LAST   = 8'(MOVE_DIV - 1);
  localparam logic [7:0] FREEZE_LAST = 8'(FREEZE_FR - 1);
  state_t state, state_n;
  logic [9:0] x, y, x_n, y_n, cx, cy;
  logic [1:0] dir, dir_n, pd, sd, mv;
  logic [7:0] lives, lives_n, move_cnt, move_cnt_n, freeze_cnt, freeze_cnt_n;
  logic hit, hit_n, ax_x, pv, sv, found, catch_now;
  logic signed [10:0] dx, dy;
  logic [10:0] adx, ady;
  logic signed [11:0] sx, sy;
  logic [3:0] blk;
  // distance to pacman and the first unblocked heading in preference order, with the clamped step target
  always_comb begin
    dx = $signed({1'b0, bus.pX}) - $signed({1'b0, x});
    dy = $signed({1'b0, bus.pY}) - $signed({1'b0, y});
    adx = dx[10] ? 11'(-dx) : 11'(dx);
    ady = dy[10] ? 11'(-dy) : 11'(dy);
    catch_now = adx < 11'(HIT_DIST) && ady < 11'(HIT_DIST);
    blk = {bus.wall_right, bus.wall_down, bus.wall_left, bus.wall_up};
    ax_x = adx >= ady;
    pv = ax_x ? dx != 11'sd0 : dy != 11'sd0;
    pd = ax_x ? (dx[10] ? 2'd1 : 2'd3) : (dy[10] ? 2'd0 : 2'd2);
    sv = ax_x ? dy != 11'sd0 : dx != 11'sd0;
    sd = ax_x ? (dy[10] ? 2'd0 : 2'd2) : (dx[10] ? 2'd1 : 2'd3);
    found = blk != 4'hf;
    mv = (pv && !blk[pd]) ? pd : (sv && !blk[sd]) ? sd : !blk[dir] ? dir :
         !blk[0] ? 2'd0 : !blk[1] ? 2'd1 : !blk[2] ? 2'd2 : 2'd3;
    sx = $signed({2'b0, x}) + (mv == 2'd3 ? ST : mv == 2'd1 ? -ST : 12'sd0);
    sy = $signed({2'b0, y}) + (mv == 2'd2 ? ST : mv == 2'd0 ? -ST : 12'sd0);
    cx = sx < LO ? 10'(LO) : sx > XHI ? 10'(XHI) : 10'(sx);
    cy = sy < LO ? 10'(LO) : sy > YHI ? 10'(YHI) : 10'(sy);
  end
  // next state: everything holds unless a frame tick arrives while the game is enabled
  always_comb begin
    state_n = state;
    x_n = x;
    y_n = y;
    dir_n = dir;
    lives_n = lives;
    move_cnt_n = move_cnt;
    freeze_cnt_n = freeze_cnt;
    hit_n = 1'b0;
    if (bus.frame_tick && bus.game_en) begin
      case (state)
        IDLE: state_n = CHASE;
        CHASE: begin
          if (catch_now) begin
            hit_n = 1'b1;
            lives_n = lives == 8'd0 ? 8'd0 : lives - 8'd1;
            state_n = lives <= 8'd1 ? OVER : HIT;
            freeze_cnt_n = 8'd0;
          end else if (move_cnt == MOVE_LAST) begin
            move_cnt_n = 8'd0;
            if (found) begin
              dir_n = mv;
              x_n = cx;
              y_n = cy;
            end
          end else move_cnt_n = move_cnt + 8'd1;
        end
        HIT: begin
          if (freeze_cnt == FREEZE_LAST) begin
            state_n = CHASE;
            x_n = 10'(START_X);
            y_n = 10'(START_Y);
            move_cnt_n = 8'd0;
            freeze_cnt_n = 8'd0;
          end else freeze_cnt_n = freeze_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end
  // state registers with asynchronous active-low reset to the home position
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      x <= 10'(START_X);
      y <= 10'(START_Y);
      dir <= 2'd0;
      lives <= 8'(LIVES_INIT);
      move_cnt <= 8'd0;
      freeze_cnt <= 8'd0;
      hit <= 1'b0;
    end else begin
      state <= state_n;
      x <= x_n;
      y <= y_n;
      dir <= dir_n;
      lives <= lives_n;
      move_cnt <= move_cnt_n;
      freeze_cnt <= freeze_cnt_n;
      hit <= hit_n;
    end
  end
  assign bus.redghostX = x;
  assign bus.redghostY = y;
  assign bus.redghost_size = 10'(SIZE);
  assign bus.lives = lives;
  assign bus.dir = dir;
  assign bus.hit = hit;
  assign bus.game_over = state == OVER;
endmodule

// File: tb/tb_redghost_controller.sv
// tb_redghost_controller: directed scoreboard bench for the red-ghost engine
module tb_redghost_controller;
  logic Clk = 1'b0;
  logic Reset;
  int checks = 0;
  int errors = 0;
  typedef struct { string tag; int x, y, d, l, h, g; } exp_t;
  exp_t q[$];
  redghost_controller_if bus();
  redghost_controller dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int x, y, d, l, h, g);
    q.push_back('{tag, x, y, d, l, h, g});
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, ".x"}, 32'(bus.redghostX), e.x);
      chk({e.tag, ".y"}, 32'(bus.redghostY), e.y);
      chk({e.tag, ".dir"}, 32'(bus.dir), e.d);
      chk({e.tag, ".lives"}, 32'(bus.lives), e.l);
      chk({e.tag, ".hit"}, 32'(bus.hit), e.h);
      chk({e.tag, ".over"}, 32'(bus.game_over), e.g);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    bus.frame_tick = 1'b1;
    @(negedge Clk);
    bus.frame_tick = 1'b0;
  endtask

  initial begin
    Reset = 1'b0;
    bus.frame_tick = 1'b0;
    bus.game_en = 1'b0;
    bus.pX = 10'd300;
    bus.pY = 10'd200;
    {bus.wall_up, bus.wall_down, bus.wall_left, bus.wall_right} = 4'b0;
    repeat (2) @(negedge Clk);
    push("reset", 202, 200, 0, 3, 0, 0);
    drain();
    chk("size", 32'(bus.redghost_size), 12);
    Reset = 1'b1;
    bus.game_en = 1'b1;
    push("idle_tick", 202, 200, 0, 3, 0, 0);
    tick();
    drain();
    for (int i = 1; i <= 6; i++) begin
      push($sformatf("chase%0d", i), 202 + i / 2, 200, i >= 2 ? 3 : 0, 3, 0, 0);
      tick();
      drain();
    end
    bus.wall_right = 1'b1;
    push("wr_cnt", 205, 200, 3, 3, 0, 0);
    tick();
    drain();
    push("wr_up", 205, 199, 0, 3, 0, 0);
    tick();
    drain();
    push("sec_cnt", 205, 199, 0, 3, 0, 0);
    tick();
    drain();
    push("sec_down", 205, 200, 2, 3, 0, 0);
    tick();
    drain();
    bus.wall_right = 1'b0;
    push("pre_hold", 205, 200, 2, 3, 0, 0);
    tick();
    drain();
    bus.game_en = 1'b0;
    bus.pX = 10'd210;
    bus.pY = 10'd205;
    repeat (10) tick();
    push("disabled", 205, 200, 2, 3, 0, 0);
    drain();
    bus.game_en = 1'b1;
    bus.pX = 10'd300;
    bus.pY = 10'd200;
    push("resume_move", 206, 200, 3, 3, 0, 0);
    tick();
    drain();
    bus.pX = 10'd226;
    bus.pY = 10'd219;
    push("dist20_nohit", 206, 200, 3, 3, 0, 0);
    tick();
    drain();
    bus.pX = 10'd225;
    push("catch1", 206, 200, 3, 2, 1, 0);
    tick();
    drain();
    @(negedge Clk);
    push("hit_pulse_end", 206, 200, 3, 2, 0, 0);
    drain();
    bus.pX = 10'd300;
    bus.pY = 10'd200;
    repeat (59) tick();
    push("frozen", 206, 200, 3, 2, 0, 0);
    drain();
    push("respawn", 202, 200, 3, 2, 0, 0);
    tick();
    drain();
    push("post_cnt", 202, 200, 3, 2, 0, 0);
    tick();
    drain();
    push("post_move", 203, 200, 3, 2, 0, 0);
    tick();
    drain();
    bus.pX = 10'd210;
    bus.pY = 10'd205;
    push("catch2", 203, 200, 3, 1, 1, 0);
    tick();
    drain();
    repeat (60) tick();
    push("respawn2", 202, 200, 3, 1, 0, 0);
    drain();
    push("catch_last", 202, 200, 3, 0, 1, 1);
    tick();
    drain();
    bus.pX = 10'd300;
    repeat (3) tick();
    bus.game_en = 1'b0;
    repeat (2) tick();
    bus.game_en = 1'b1;
    repeat (3) tick();
    push("over_sticky", 202, 200, 3, 0, 0, 1);
    drain();
    Reset = 1'b0;
    #1;
    push("reset_over", 202, 200, 0, 3, 0, 0);
    drain();
    @(negedge Clk);
    Reset = 1'b1;
    tick();
    bus.pX = 10'd210;
    bus.pY = 10'd205;
    push("catch3", 202, 200, 0, 2, 1, 0);
    tick();
    drain();
    repeat (5) tick();
    @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    push("reset_mid_hit", 202, 200, 0, 3, 0, 0);
    drain();
    @(negedge Clk);
    Reset = 1'b1;
    bus.pX = 10'd300;
    bus.pY = 10'd200;
    repeat (3) tick();
    push("after_reset", 203, 200, 3, 3, 0, 0);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
